// File: rtl/motor_ramp_sequencer.sv
// Duty-cycle ramp sequencer for a PWM motor drive: soft start/stop, dead time
// before direction reversal and an emergency-stop fault state.
module motor_ramp_sequencer #(
    parameter int unsigned RAMP_DIV   = 500,
    parameter int unsigned STEP       = 1,
    parameter int unsigned DEAD_TICKS = 1000
) (
    input  logic       Clock500K,
    input  logic       Reset_n,
    input  logic       enable,
    input  logic       estop,
    input  logic [7:0] target_duty,
    input  logic       target_dir,
    output logic [7:0] duty_cycle,
    output logic       motor_en,
    output logic       dir,
    output logic       at_target,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_RAMP_DN = 3'd2,
        ST_DEAD    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(RAMP_DIV - 1);
    localparam logic [15:0] DEAD_LAST = 16'(DEAD_TICKS - 1);
    localparam logic [8:0]  STEP_W    = 9'(STEP);
    localparam logic [7:0]  STEP_B    = 8'(STEP);

    state_t      state_r, state_nxt_s;
    logic [7:0]  duty_r, duty_nxt_s;
    logic        dir_r, dir_nxt_s;
    logic        motor_en_r, motor_en_nxt_s;
    logic        at_target_r, at_target_nxt_s;
    logic [15:0] presc_r, presc_nxt_s;
    logic [15:0] dead_cnt_r, dead_cnt_nxt_s;
    logic        tick_s;

    // One STEP toward the target, clamped so the target is never overshot.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] sum_v;
        logic [7:0] res_v;
        sum_v = {1'b0, cur} + STEP_W;
        if (cur < tgt) begin
            res_v = (sum_v >= {1'b0, tgt}) ? tgt : sum_v[7:0];
        end else if (cur > tgt) begin
            res_v = ({1'b0, cur} >= ({1'b0, tgt} + STEP_W)) ? (cur - STEP_B) : tgt;
        end else begin
            res_v = cur;
        end
        return res_v;
    endfunction

    function automatic logic [7:0] step_down(input logic [7:0] cur);
        logic [7:0] res_v;
        if ({1'b0, cur} > STEP_W) begin
            res_v = cur - STEP_B;
        end else begin
            res_v = 8'd0;
        end
        return res_v;
    endfunction

    assign tick_s = (presc_r == DIV_LAST);

    // Next-state, duty and direction selection; estop overrides everything.
    always_comb begin
        state_nxt_s    = state_r;
        duty_nxt_s     = duty_r;
        dir_nxt_s      = dir_r;
        dead_cnt_nxt_s = 16'd0;
        if (estop) begin
            state_nxt_s = ST_FAULT;
            duty_nxt_s  = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    duty_nxt_s = 8'd0;
                    if (enable) begin
                        state_nxt_s = ST_RUN;
                        dir_nxt_s   = target_dir;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A tick coinciding with a stop or reversal request is dropped.
                    if (!enable || (target_dir != dir_r)) begin
                        state_nxt_s = ST_RAMP_DN;
                    end else if (tick_s) begin
                        duty_nxt_s = step_toward(duty_r, target_duty);
                    end else begin
                        duty_nxt_s = duty_r;
                    end
                end
                ST_RAMP_DN: begin
                    if (duty_r == 8'd0) begin
                        state_nxt_s = enable ? ST_DEAD : ST_IDLE;
                    end else if (tick_s) begin
                        duty_nxt_s = step_down(duty_r);
                    end else begin
                        duty_nxt_s = duty_r;
                    end
                end
                ST_DEAD: begin
                    duty_nxt_s = 8'd0;
                    if (dead_cnt_r == DEAD_LAST) begin
                        if (enable) begin
                            state_nxt_s = ST_RUN;
                            dir_nxt_s   = target_dir;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        dead_cnt_nxt_s = dead_cnt_r + 16'd1;
                    end
                end
                ST_FAULT: begin
                    duty_nxt_s = 8'd0;
                    if (!enable) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FAULT;
                    end
                end
                default: begin
                    state_nxt_s = ST_FAULT;
                    duty_nxt_s  = 8'd0;
                end
            endcase
        end
    end

    // Prescaler and registered-output precomputation from the next state.
    always_comb begin
        presc_nxt_s = 16'd0;
        if ((state_nxt_s != state_r) || tick_s) begin
            presc_nxt_s = 16'd0;
        end else begin
            presc_nxt_s = presc_r + 16'd1;
        end
        motor_en_nxt_s  = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_RAMP_DN);
        at_target_nxt_s = (state_nxt_s == ST_RUN) && (duty_nxt_s == target_duty)
                          && (dir_nxt_s == target_dir);
    end

    // State and output registers.
    always_ff @(posedge Clock500K or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= ST_IDLE;
            duty_r      <= 8'd0;
            dir_r       <= 1'b0;
            motor_en_r  <= 1'b0;
            at_target_r <= 1'b0;
            presc_r     <= 16'd0;
            dead_cnt_r  <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            duty_r      <= duty_nxt_s;
            dir_r       <= dir_nxt_s;
            motor_en_r  <= motor_en_nxt_s;
            at_target_r <= at_target_nxt_s;
            presc_r     <= presc_nxt_s;
            dead_cnt_r  <= dead_cnt_nxt_s;
        end
    end

    assign duty_cycle = duty_r;
    assign motor_en   = motor_en_r;
    assign dir        = dir_r;
    assign at_target  = at_target_r;
    assign state      = state_r;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer with RAMP_DIV=4, STEP=16, DEAD_TICKS=8.
module tb_motor_ramp_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       estop = 1'b0;
    logic [7:0] target_duty = 8'd0;
    logic       target_dir = 1'b0;
    logic [7:0] duty_cycle;
    logic       motor_en;
    logic       dir;
    logic       at_target;
    logic [2:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       en;
        logic       es;
        logic [7:0] td;
        logic       tdir;
        int         cyc;
        logic [2:0] st;
        logic [7:0] duty;
        logic       me;
        logic       dr;
        logic       at;
    } vec_t;

    vec_t tbl [0:19];

    motor_ramp_sequencer #(.RAMP_DIV(4), .STEP(16), .DEAD_TICKS(8)) dut (
        .Clock500K  (clk),
        .Reset_n    (rst_n),
        .enable     (enable),
        .estop      (estop),
        .target_duty(target_duty),
        .target_dir (target_dir),
        .duty_cycle (duty_cycle),
        .motor_en   (motor_en),
        .dir        (dir),
        .at_target  (at_target),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] es, input logic [7:0] ed,
                         input logic eme, input logic edr, input logic eat);
        tests_run++;
        if (state !== es || duty_cycle !== ed || motor_en !== eme || dir !== edr || at_target !== eat) begin
            tests_failed++;
            $display("FAIL %s: got state=%0d duty=%0d motor_en=%0b dir=%0b at_target=%0b, expected state=%0d duty=%0d motor_en=%0b dir=%0b at_target=%0b",
                     name, state, duty_cycle, motor_en, dir, at_target, es, ed, eme, edr, eat);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        estop = 1'b0;
        target_duty = 8'd0;
        target_dir = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        //           en    es    td     tdir  cyc  st    duty    me    dir   at
        tbl[0]  = '{1'b0, 1'b0, 8'd64, 1'b0, 2,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'd64, 1'b0, 1,  3'd1, 8'd0,  1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'd64, 1'b0, 3,  3'd1, 8'd0,  1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'd64, 1'b0, 1,  3'd1, 8'd16, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'd64, 1'b0, 4,  3'd1, 8'd32, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'd64, 1'b0, 4,  3'd1, 8'd48, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'd64, 1'b0, 4,  3'd1, 8'd64, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 8'd64, 1'b0, 8,  3'd1, 8'd64, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 8'd64, 1'b1, 1,  3'd2, 8'd64, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'd64, 1'b1, 4,  3'd2, 8'd48, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'd64, 1'b1, 4,  3'd2, 8'd32, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'd64, 1'b1, 4,  3'd2, 8'd16, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'd64, 1'b1, 4,  3'd2, 8'd0,  1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'd64, 1'b1, 1,  3'd3, 8'd0,  1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 8'd64, 1'b0, 3,  3'd3, 8'd0,  1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 8'd64, 1'b1, 4,  3'd3, 8'd0,  1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'd64, 1'b1, 1,  3'd1, 8'd0,  1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 8'd64, 1'b1, 4,  3'd1, 8'd16, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 8'd64, 1'b1, 8,  3'd1, 8'd48, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 8'd64, 1'b1, 4,  3'd1, 8'd64, 1'b1, 1'b1, 1'b1};

        // Main ramp up, reversal through ramp-down and dead time.
        do_reset();
        check("reset", 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            enable      = tbl[i].en;
            estop       = tbl[i].es;
            target_duty = tbl[i].td;
            target_dir  = tbl[i].tdir;
            step(tbl[i].cyc);
            check($sformatf("vec%0d", i), tbl[i].st, tbl[i].duty, tbl[i].me, tbl[i].dr, tbl[i].at);
        end

        // Saturation at a target that is not a multiple of STEP.
        do_reset();
        enable = 1'b1;
        target_duty = 8'd40;
        step(1);  check("sat_run",  3'd1, 8'd0,  1'b1, 1'b0, 1'b0);
        step(4);  check("sat_16",   3'd1, 8'd16, 1'b1, 1'b0, 1'b0);
        step(4);  check("sat_32",   3'd1, 8'd32, 1'b1, 1'b0, 1'b0);
        step(4);  check("sat_40",   3'd1, 8'd40, 1'b1, 1'b0, 1'b1);
        step(4);  check("sat_hold", 3'd1, 8'd40, 1'b1, 1'b0, 1'b1);

        // Emergency stop and fault exit rules.
        do_reset();
        enable = 1'b1;
        target_duty = 8'd64;
        step(13); check("es_48",    3'd1, 8'd48, 1'b1, 1'b0, 1'b0);
        estop = 1'b1;
        step(1);  check("es_fault", 3'd4, 8'd0,  1'b0, 1'b0, 1'b0);
        estop = 1'b0;
        step(3);  check("es_hold",  3'd4, 8'd0,  1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        step(1);  check("es_idle",  3'd0, 8'd0,  1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        estop = 1'b1;
        step(1);  check("es_prio",  3'd4, 8'd0,  1'b0, 1'b0, 1'b0);
        estop = 1'b0;
        enable = 1'b0;
        step(1);  check("es_idle2", 3'd0, 8'd0,  1'b0, 1'b0, 1'b0);

        // Short asynchronous reset pulse mid-ramp.
        do_reset();
        enable = 1'b1;
        target_duty = 8'd64;
        step(9);  check("rst_32",    3'd1, 8'd32, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;       check("rst_async", 3'd0, 8'd0,  1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1);  check("rst_run",   3'd1, 8'd0,  1'b1, 1'b0, 1'b0);
        step(3);  check("rst_noglt", 3'd1, 8'd0,  1'b1, 1'b0, 1'b0);
        step(1);  check("rst_16",    3'd1, 8'd16, 1'b1, 1'b0, 1'b0);

        // Enable falls in the same cycle as a step tick.
        do_reset();
        enable = 1'b1;
        target_duty = 8'd64;
        step(12); check("ef_32",   3'd1, 8'd32, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        step(1);  check("ef_drop", 3'd2, 8'd32, 1'b1, 1'b0, 1'b0);
        step(4);  check("ef_16",   3'd2, 8'd16, 1'b1, 1'b0, 1'b0);
        step(4);  check("ef_0",    3'd2, 8'd0,  1'b1, 1'b0, 1'b0);
        step(1);  check("ef_idle", 3'd0, 8'd0,  1'b0, 1'b0, 1'b0);

        // Ramp-down entered with zero duty exits on the next cycle.
        enable = 1'b1;
        step(1);  check("z_run",  3'd1, 8'd0, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        step(1);  check("z_rdn",  3'd2, 8'd0, 1'b1, 1'b0, 1'b0);
        step(1);  check("z_idle", 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
